// File: rtl/mac_kbd_pkg.sv
// rtl/mac_kbd_pkg.sv - shared state and command definitions for the Mac keyboard link
package mac_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_CMD,
        WAIT_HOST,
        WAIT_DATA,
        TX_RSP
    } kbd_state_t;

    // Command bytes the Mac sends on the keyboard line
    typedef enum logic [7:0] {
        CMD_INQUIRY = 8'h10,
        CMD_INSTANT = 8'h14,
        CMD_MODEL   = 8'h16,
        CMD_TEST    = 8'h36
    } kbd_cmd_t;

    // Reply when an Inquiry expires with no key pending
    localparam logic [7:0] NULL_DEFAULT = 8'h7B;

endpackage

// File: rtl/mac_kbd_fifo.sv
// rtl/mac_kbd_fifo.sv - first-word fall-through key-code FIFO with flush and sticky overflow
module mac_kbd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk32,
    input  logic             _systemReset,
    input  logic             ce,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign rdata = mem[rd_ptr];

    // A pop frees a slot on the same ce, so a push into a full FIFO still lands;
    // a pop request against an empty FIFO never consumes the byte arriving alongside it.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Storage write port
    always_ff @(posedge clk32) begin
        if (ce && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (ce) begin
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                if (do_push && !do_pop) begin
                    count <= count + (AW+1)'(1);
                end else if (do_pop && !do_push) begin
                    count <= count - (AW+1)'(1);
                end
                if (push && !do_push) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_kbd_link.sv
// rtl/mac_kbd_link.sv - Mac keyboard-line transceiver: clock generator, command receive, key reply
module mac_kbd_link
    import mac_kbd_pkg::*;
#(
    parameter int          HALF_PERIOD = 1300,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          TIMEOUT     = 2031250,
    parameter logic [7:0]  NULL_CODE   = NULL_DEFAULT
) (
    input  logic       clk32,
    input  logic       _systemReset,
    input  logic       ce,
    input  logic       srst,
    input  logic       dat_i,
    output logic       kbdclk,
    output logic       kbddata_o,
    input  logic [7:0] key_data,
    input  logic       key_strobe,
    output logic [7:0] cmd_data,
    output logic       cmd_strobe,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy
);
    localparam int HC_W = $clog2(HALF_PERIOD + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    kbd_state_t      state;
    kbd_state_t      state_n;
    logic [HC_W-1:0] hp_cnt;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic [7:0]      txreg;
    logic [TO_W-1:0] tcnt;

    logic       active;
    logic       tick;
    logic       fall_ev;
    logic       rise_ev;
    logic       last_rise;
    logic       to_hit;
    logic       fifo_pop;
    logic       load_null;
    logic       tcnt_clr;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;

    // The line clock only runs while a byte is moving in either direction
    assign active    = (state == RX_CMD) || (state == TX_RSP);
    assign tick      = active && (hp_cnt == HC_W'(HALF_PERIOD - 1));
    assign fall_ev   = tick && kbdclk;
    assign rise_ev   = tick && !kbdclk;
    assign last_rise = rise_ev && (bitcnt == 3'd7);
    assign to_hit    = (tcnt == TO_W'(TIMEOUT - 1));
    assign busy      = (state != IDLE);

    mac_kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk32        (clk32),
        ._systemReset (_systemReset),
        .ce           (ce),
        .flush        (srst),
        .push         (key_strobe),
        .wdata        (key_data),
        .pop          (fifo_pop),
        .rdata        (fifo_rdata),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow     (overflow)
    );

    // State register
    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= srst ? IDLE : state_n;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_n   = state;
        fifo_pop  = 1'b0;
        load_null = 1'b0;
        tcnt_clr  = 1'b0;
        case (state)
            IDLE:      if (!dat_i) state_n = RX_CMD;
            RX_CMD:    if (last_rise) begin
                           state_n  = WAIT_HOST;
                           tcnt_clr = 1'b1;
                       end
            WAIT_HOST: if (dat_i) state_n = WAIT_DATA;
            WAIT_DATA: if (!fifo_empty) begin
                           fifo_pop = 1'b1;
                           state_n  = TX_RSP;
                       end else if (to_hit) begin
                           if (cmd_data == CMD_INQUIRY) begin
                               load_null = 1'b1;
                               state_n   = TX_RSP;
                           end else begin
                               state_n = IDLE;
                           end
                       end
            TX_RSP:    if (last_rise) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Line clock, bit framing, shift registers and response timer
    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            hp_cnt     <= '0;
            kbdclk     <= 1'b1;
            bitcnt     <= '0;
            shreg      <= '0;
            txreg      <= '0;
            tcnt       <= '0;
            kbddata_o  <= 1'b1;
            cmd_data   <= '0;
            cmd_strobe <= 1'b0;
        end else if (ce) begin
            if (srst) begin
                hp_cnt     <= '0;
                kbdclk     <= 1'b1;
                bitcnt     <= '0;
                shreg      <= '0;
                txreg      <= '0;
                tcnt       <= '0;
                kbddata_o  <= 1'b1;
                cmd_data   <= '0;
                cmd_strobe <= 1'b0;
            end else begin
                cmd_strobe <= 1'b0;

                if (!active) begin
                    hp_cnt <= '0;
                    kbdclk <= 1'b1;
                end else if (tick) begin
                    hp_cnt <= '0;
                    kbdclk <= !kbdclk;
                end else begin
                    hp_cnt <= hp_cnt + HC_W'(1);
                end

                if (!active) begin
                    bitcnt <= '0;
                end else if (rise_ev) begin
                    bitcnt <= bitcnt + 3'd1;
                end

                // Mac drives the line; capture it as the clock falls
                if (state == RX_CMD && fall_ev) begin
                    shreg <= {shreg[6:0], dat_i};
                end
                if (state == RX_CMD && last_rise) begin
                    cmd_data   <= shreg;
                    cmd_strobe <= 1'b1;
                end

                if (tcnt_clr) begin
                    tcnt <= '0;
                end else if ((state == WAIT_HOST || state == WAIT_DATA) && !to_hit) begin
                    tcnt <= tcnt + TO_W'(1);
                end

                if (fifo_pop) begin
                    txreg <= fifo_rdata;
                end else if (load_null) begin
                    txreg <= NULL_CODE;
                end else if (state == TX_RSP && fall_ev) begin
                    txreg <= {txreg[6:0], 1'b0};
                end

                // Each reply bit appears on a fall and stays put across the next rise
                if (state == TX_RSP) begin
                    if (fall_ev) begin
                        kbddata_o <= txreg[7];
                    end else if (last_rise) begin
                        kbddata_o <= 1'b1;
                    end
                end else begin
                    kbddata_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mac_kbd_link.md
Name: mac_kbd_link

Overview:
- Parametrised Mac keyboard-line transceiver, successor to the inline keyboard clock/shift logic in the data controller.
- Generates the keyboard clock (feeds VIA CB1). Clocks in 8-bit commands from the Mac over the CB2 line.
- Buffers key codes from the PS/2 translator in a FIFO and returns one byte per command.
- Sends the NULL code itself when an Inquiry times out with no key available.

Parameters:
- HALF_PERIOD, 1300: ce ticks per kbdclk half-period (~160 us at 8.125 MHz).
- FIFO_DEPTH, 4: key-code FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT, 2031250: ce ticks to wait for a response byte after a command (0.25 s).
- NULL_CODE, 8'h7B: byte sent on Inquiry timeout.

Ports:
- clk32  in  1  system clock.
- _systemReset  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable (clk8_en_p). All state advances only when ce=1.
- srst  in  1  synchronous soft reset (driven by !_cpuReset). Sampled on ce.
- dat_i  in  1  resolved Mac-side data line (~cb2_t | cb2_o).
- kbdclk  out  1  keyboard clock to VIA CB1.
- kbddata_o  out  1  keyboard-driven data to VIA CB2 input.
- key_data  in  8  key code from the translator.
- key_strobe  in  1  push key_data; one ce cycle wide.
- cmd_data  out  8  last command received.
- cmd_strobe  out  1  one-ce pulse when cmd_data becomes valid.
- fifo_full  out  1  FIFO at capacity.
- overflow  out  1  sticky: a push was dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async _systemReset, or srst on ce): kbdclk=1, kbddata_o=1, cmd_data=0, cmd_strobe=0, overflow=0, busy=0, FIFO empty, state=IDLE, all counters 0.
- Clock generator:
  - Runs only in RX_CMD and TX_RSP.
  - Counter counts 0..HALF_PERIOD-1; at terminal count it wraps and toggles kbdclk.
  - In any other state, counter=0 and kbdclk=1.
  - Falling event = toggle while kbdclk=1. Rising event = toggle while kbdclk=0.
- Bit counter: 3 bits, incremented on each rising event. 8 rising events make one byte.
- State machine:
  - IDLE:
    - dat_i=0 -> RX_CMD, bitcnt=0.
    - dat_i=1 -> stay IDLE.
  - RX_CMD:
    - kbddata_o held at 1.
    - On each falling event, shift dat_i into a shift register, MSB first.
    - On the 8th rising event: cmd_data <= shift register, cmd_strobe=1 for one ce, timeout counter=0 -> WAIT_HOST.
  - WAIT_HOST:
    - Clock idle.
    - dat_i=1 -> WAIT_DATA.
    - The timeout counter also runs in this state.
  - WAIT_DATA:
    - FIFO non-empty -> pop into tx register, go TX_RSP.
    - Else timeout counter increments. At TIMEOUT-1:
      - cmd_data==8'h10 (Inquiry) -> tx register = NULL_CODE, go TX_RSP.
      - Any other command -> go IDLE with nothing sent.
  - TX_RSP:
    - Bit k (MSB first) drives kbddata_o on each falling event and is held through the following rising event.
    - On the 8th rising event: kbddata_o=1 -> IDLE.
- FIFO:
  - Synchronous, first-word fall-through, depth FIFO_DEPTH.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
  - Push while full: byte dropped, overflow<=1 (cleared only by reset).
  - Push and pop on the same ce: both happen, occupancy unchanged. This is allowed even when full.
  - Push while empty with a pop request in the same ce: no pop. The byte is available on the next ce.
- Dropped events:
  - dat_i glitches low in WAIT_DATA or TX_RSP are ignored.
  - key_strobe is accepted in every state.
- srst mid-transfer: immediate return to IDLE, kbdclk=1, kbddata_o=1, FIFO flushed, partial byte discarded.

Decomposition:
- Package mac_kbd_pkg holds:
  - state enum {IDLE, RX_CMD, WAIT_HOST, WAIT_DATA, TX_RSP}.
  - Constants CMD_INQUIRY=8'h10, CMD_INSTANT=8'h14, CMD_MODEL=8'h16, CMD_TEST=8'h36, NULL_DEFAULT=8'h7B.
- One sub-module, mac_kbd_fifo (parametrised depth/width, full/empty, flush input).
- Clock generator and state machine stay in mac_kbd_link.

Test Plan:
- Command receive (HALF_PERIOD=4, ce every cycle): Mac model drives dat_i low, then presents 8'h10 MSB-first, sampling at kbdclk falls -> exactly 8 kbdclk periods, cmd_strobe single pulse, cmd_data=8'h10, state WAIT_HOST.
- Key response: push 8'h2A before the command, then Mac releases dat_i -> kbddata_o bits 0,0,1,0,1,0,1,0 at the 8 rising edges, FIFO empty afterwards, back to IDLE, kbddata_o=1.
- Inquiry timeout (TIMEOUT=100): no key pushed, command 8'h10 -> after 100 ce in WAIT_DATA, 8'h7B transmitted. Same with command 8'h16 -> returns to IDLE, kbdclk stays 1, nothing sent.
- Late key: push 8'h33 at ce 50 of WAIT_DATA (TIMEOUT=100) -> 8'h33 sent, not NULL.
- FIFO stress (FIFO_DEPTH=4): push 5 bytes 1..5 -> fifo_full=1, overflow=1, responses 1,2,3,4. Simultaneous push/pop when full keeps occupancy at 4.
- Reset mid-op: assert srst at bit 3 of TX_RSP -> next ce kbdclk=1, kbddata_o=1, busy=0, FIFO empty. Repeat with async _systemReset low between clocks -> outputs change immediately without a clock edge.
